y_sram_arbiter: RTL and testbench

//  Parametrised, registered arbiter for the Y SRAM port. NUM_CH requesters (control path, write path, ...) request via req/gnt.

---
 rtl/y_sram_pkg.sv | 15 +
 rtl/y_sram_arbiter_rr_pick.sv | 36 +++
 rtl/y_sram_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_y_sram_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y_sram_pkg.sv
// rtl/y_sram_pkg.sv - shared types and constants for the Y SRAM arbiter
package y_sram_pkg;

    localparam int Y_ADDR_W = 11;
    localparam int Y_DATA_W = 256;

    // Idle SRAM address bit; replicated to all-ones on the address buses
    localparam logic Y_ADDR_IDLE = 1'b1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/y_sram_arbiter_rr_pick.sv
// rtl/y_sram_arbiter_rr_pick.sv - combinational round-robin selector
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] in_req,
    input  logic [PW-1:0]     in_ptr,
    output logic [NUM_CH-1:0] op_win,
    output logic              op_any
);

    int w_off;
    int w_best;
    int w_win;

    // Winner is the requester at the smallest distance upward from in_ptr
    always_comb begin
        w_off  = 0;
        w_best = NUM_CH;
        w_win  = 0;
        op_win = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_off = (i + NUM_CH - int'(in_ptr)) % NUM_CH;
            if (in_req[i] && (w_off < w_best)) begin
                w_best = w_off;
                w_win  = i;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            op_win[i] = in_req[i] && (i == w_win);
        end
    end

    assign op_any = |in_req;

endmodule

// File: rtl/y_sram_arbiter.sv
// rtl/y_sram_arbiter.sv - registered round-robin arbiter for the Y SRAM port (option: Y_ARB_STRICT_CH0_EN)
module y_sram_arbiter
    import y_sram_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = Y_ADDR_W,
    parameter int DATA_W   = Y_DATA_W,
    parameter int MAX_HOLD = 16,
    parameter int RD_LAT   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_req,
    input  logic [NUM_CH*ADDR_W-1:0] in_rdAddr1,
    input  logic [NUM_CH*ADDR_W-1:0] in_rdAddr2,
    input  logic [NUM_CH-1:0]        in_we,
    input  logic [NUM_CH*ADDR_W-1:0] in_wrAddr,
    input  logic [NUM_CH*DATA_W-1:0] in_wrData,
    input  logic [DATA_W-1:0]        in_ReadData1,
    input  logic [DATA_W-1:0]        in_ReadData2,
    output logic [NUM_CH-1:0]        op_gnt,
    output logic [ADDR_W-1:0]        op_yReadAddress1,
    output logic [ADDR_W-1:0]        op_yReadAddress2,
    output logic                     op_yWriteEnable,
    output logic [ADDR_W-1:0]        op_yWriteAddress,
    output logic [DATA_W-1:0]        op_writeData,
    output logic [NUM_CH-1:0]        op_rdValid,
    output logic                     op_weDropErr
);

    localparam int                PW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]     HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [ADDR_W-1:0] ADDR_IDLE = {ADDR_W{Y_ADDR_IDLE}};
    localparam logic [NUM_CH-1:0] CH0_HOT   = {{(NUM_CH-1){1'b0}}, 1'b1};

    arb_state_t          r_state, w_nx_state;
    logic [NUM_CH-1:0]   r_gnt, w_nx_gnt;
    logic [PW-1:0]       r_ptr, w_nx_ptr;
    logic [HW-1:0]       r_hold, w_nx_hold;

    logic [NUM_CH-1:0]   w_pick_req;
    logic [NUM_CH-1:0]   w_pick;
    logic                w_pick_any;
    logic [PW-1:0]       w_pick_nptr;
    logic                w_cur_req;
    logic                w_others;
    logic                w_hold_hit;
    logic                w_keep;

    logic [ADDR_W-1:0]   w_sel_rd1, w_sel_rd2, w_sel_wa;
    logic [DATA_W-1:0]   w_sel_wd;
    logic                w_sel_we;
    logic                w_drop;

    logic [ADDR_W-1:0]   r_rd1, r_rd2, r_wa;
    logic [DATA_W-1:0]   r_wd;
    logic                r_we;
    logic                r_err;
    logic [NUM_CH-1:0]   r_rd_pipe [0:RD_LAT];

    // Read data fans out to all channels outside this block; rdValid qualifies it
    logic                w_unused_rdata;
    assign w_unused_rdata = ^{in_ReadData1, in_ReadData2};

    assign w_cur_req  = |(in_req & r_gnt);
    assign w_others   = |(in_req & ~r_gnt);
    assign w_hold_hit = (r_hold == HOLD_MAX);
    assign w_keep     = w_cur_req && !(w_hold_hit && w_others);

`ifdef Y_ARB_STRICT_CH0_EN
    // ch0 is handled ahead of the rotation, so the rotation only sees the others
    assign w_pick_req = in_req & ~r_gnt & ~CH0_HOT;
`else
    // The current holder is excluded so a hold expiry always moves on
    assign w_pick_req = in_req & ~r_gnt;
`endif

    rr_pick #(
        .NUM_CH (NUM_CH),
        .PW     (PW)
    ) u_rr_pick (
        .in_req (w_pick_req),
        .in_ptr (r_ptr),
        .op_win (w_pick),
        .op_any (w_pick_any)
    );

    // Pointer moves to one past the winner, wrapping at the top channel
    always_comb begin
        w_pick_nptr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_pick[i]) begin
                w_pick_nptr = (i == NUM_CH - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Grant FSM: keep, hand over without a bubble, or fall back to idle
    always_comb begin
        w_nx_state = r_state;
        w_nx_gnt   = r_gnt;
        w_nx_ptr   = r_ptr;
        w_nx_hold  = r_hold;
`ifdef Y_ARB_STRICT_CH0_EN
        if (in_req[0] && !r_gnt[0]) begin
            w_nx_state = ARB_GRANT;
            w_nx_gnt   = CH0_HOT;
            w_nx_hold  = HW'(1);
        end else if (in_req[0]) begin
            w_nx_hold  = w_hold_hit ? r_hold : r_hold + HW'(1);
        end else
`endif
        if ((r_state == ARB_GRANT) && w_keep) begin
            w_nx_hold  = w_hold_hit ? r_hold : r_hold + HW'(1);
        end else if (w_pick_any) begin
            w_nx_state = ARB_GRANT;
            w_nx_gnt   = w_pick;
            w_nx_ptr   = w_pick_nptr;
            w_nx_hold  = HW'(1);
        end else begin
            w_nx_state = ARB_IDLE;
            w_nx_gnt   = '0;
            w_nx_hold  = '0;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_nx_state;
            r_gnt   <= w_nx_gnt;
            r_ptr   <= w_nx_ptr;
            r_hold  <= w_nx_hold;
        end
    end

    // Select the granted channel's bus fields
    always_comb begin
        w_sel_rd1 = '0;
        w_sel_rd2 = '0;
        w_sel_wa  = '0;
        w_sel_wd  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_gnt[i]) begin
                w_sel_rd1 = in_rdAddr1[i*ADDR_W +: ADDR_W];
                w_sel_rd2 = in_rdAddr2[i*ADDR_W +: ADDR_W];
                w_sel_wa  = in_wrAddr[i*ADDR_W +: ADDR_W];
                w_sel_wd  = in_wrData[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_we = |(in_we & r_gnt & in_req);
    assign w_drop   = |(in_we & ~r_gnt);

    // SRAM port registers; idle parks addresses at all-ones and holds data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd1 <= ADDR_IDLE;
            r_rd2 <= ADDR_IDLE;
            r_wa  <= ADDR_IDLE;
            r_wd  <= '0;
            r_we  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (|r_gnt) begin
                r_rd1 <= w_sel_rd1;
                r_rd2 <= w_sel_rd2;
                r_wa  <= w_sel_wa;
                r_wd  <= w_sel_wd;
                r_we  <= w_sel_we;
            end else begin
                r_rd1 <= ADDR_IDLE;
                r_rd2 <= ADDR_IDLE;
                r_wa  <= ADDR_IDLE;
                r_we  <= 1'b0;
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    // Stage 0 tags the channel whose address is at the SRAM; RD_LAT more stages to data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                r_rd_pipe[k] <= '0;
            end
        end else begin
            r_rd_pipe[0] <= r_gnt;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_rd_pipe[k] <= r_rd_pipe[k-1];
            end
        end
    end

    assign op_gnt           = r_gnt;
    assign op_yReadAddress1 = r_rd1;
    assign op_yReadAddress2 = r_rd2;
    assign op_yWriteEnable  = r_we;
    assign op_yWriteAddress = r_wa;
    assign op_writeData     = r_wd;
    assign op_rdValid       = r_rd_pipe[RD_LAT];
    assign op_weDropErr     = r_err;

endmodule

// File: tb/tb_y_sram_arbiter.sv
// tb/tb_y_sram_arbiter.sv - directed self-checking bench for y_sram_arbiter
module tb_y_sram_arbiter;

    localparam int NUM_CH   = 4;
    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 256;
    localparam int MAX_HOLD = 16;
    localparam int RD_LAT   = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        in_req;
    logic [NUM_CH*ADDR_W-1:0] in_rdAddr1;
    logic [NUM_CH*ADDR_W-1:0] in_rdAddr2;
    logic [NUM_CH-1:0]        in_we;
    logic [NUM_CH*ADDR_W-1:0] in_wrAddr;
    logic [NUM_CH*DATA_W-1:0] in_wrData;
    logic [DATA_W-1:0]        in_ReadData1;
    logic [DATA_W-1:0]        in_ReadData2;
    logic [NUM_CH-1:0]        op_gnt;
    logic [ADDR_W-1:0]        op_yReadAddress1;
    logic [ADDR_W-1:0]        op_yReadAddress2;
    logic                     op_yWriteEnable;
    logic [ADDR_W-1:0]        op_yWriteAddress;
    logic [DATA_W-1:0]        op_writeData;
    logic [NUM_CH-1:0]        op_rdValid;
    logic                     op_weDropErr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    y_sram_arbiter #(
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_req           (in_req),
        .in_rdAddr1       (in_rdAddr1),
        .in_rdAddr2       (in_rdAddr2),
        .in_we            (in_we),
        .in_wrAddr        (in_wrAddr),
        .in_wrData        (in_wrData),
        .in_ReadData1     (in_ReadData1),
        .in_ReadData2     (in_ReadData2),
        .op_gnt           (op_gnt),
        .op_yReadAddress1 (op_yReadAddress1),
        .op_yReadAddress2 (op_yReadAddress2),
        .op_yWriteEnable  (op_yWriteEnable),
        .op_yWriteAddress (op_yWriteAddress),
        .op_writeData     (op_writeData),
        .op_rdValid       (op_rdValid),
        .op_weDropErr     (op_weDropErr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over one edge with the given request, release between edges
    task automatic start(input logic [NUM_CH-1:0] req);
        in_req = req;
        in_we  = '0;
        reset  = 1'b0;
        step();
        reset  = 1'b1;
    endtask

    task automatic test_reset();
        in_rdAddr1 = {11'h333, 11'h222, 11'h111, 11'h001};
        in_rdAddr2 = {11'h444, 11'h0F0, 11'h00F, 11'h002};
        in_wrAddr  = {11'h123, 11'h321, 11'h155, 11'h003};
        in_wrData  = {NUM_CH*DATA_W{1'b1}};
        in_req = 4'b1111;
        in_we  = 4'b0000;
        reset  = 1'b0;
        step();
        step();
        n_checks++; if (op_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", op_gnt); end
        n_checks++; if (op_yReadAddress1 !== 11'h7FF) begin n_fail++; $display("FAIL reset_rd1: got %h want 7ff", op_yReadAddress1); end
        n_checks++; if (op_yReadAddress2 !== 11'h7FF) begin n_fail++; $display("FAIL reset_rd2: got %h want 7ff", op_yReadAddress2); end
        n_checks++; if (op_yWriteAddress !== 11'h7FF) begin n_fail++; $display("FAIL reset_wa: got %h want 7ff", op_yWriteAddress); end
        n_checks++; if (op_yWriteEnable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", op_yWriteEnable); end
        n_checks++; if (op_writeData !== '0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", op_writeData); end
        n_checks++; if (op_rdValid !== 4'b0000) begin n_fail++; $display("FAIL reset_rdvalid: got %b want 0000", op_rdValid); end
        n_checks++; if (op_weDropErr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", op_weDropErr); end
        reset = 1'b1;
        step();
        n_checks++; if (op_gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_release_gnt: got %b want 0001", op_gnt); end
        in_req = 4'b0000;
    endtask

    task automatic test_reset_midflight();
        start(4'b0001);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (op_gnt !== 4'b0000) begin n_fail++; $display("FAIL async_reset_gnt: got %b want 0000", op_gnt); end
        in_req = 4'b0000;
        step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++; if (op_rdValid !== 4'b0000) begin n_fail++; $display("FAIL midflight_rdvalid c%0d: got %b want 0000", c, op_rdValid); end
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_CH-1:0] exp;
        start(4'b0110);
        for (int c = 0; c < 3 * MAX_HOLD; c++) begin
            step();
            exp = ((c / MAX_HOLD) % 2 == 0) ? 4'b0010 : 4'b0100;
            n_checks++; if (op_gnt !== exp) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b want %b", c, op_gnt, exp); end
        end
        in_req = 4'b0000;
    endtask

    task automatic test_back_to_back();
        start(4'b0010);
        step();
        n_checks++; if (op_gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_first: got %b want 0010", op_gnt); end
        in_req = 4'b0100;
        step();
        n_checks++; if (op_gnt !== 4'b0100) begin n_fail++; $display("FAIL b2b_switch: got %b want 0100", op_gnt); end
        in_req = 4'b0000;
        step();
        n_checks++; if (op_gnt !== 4'b0000) begin n_fail++; $display("FAIL b2b_idle: got %b want 0000", op_gnt); end
    endtask

    task automatic test_write();
        logic [DATA_W-1:0] exp_wd;
        exp_wd = {32{8'hA5}};
        in_rdAddr1[2*ADDR_W +: ADDR_W] = 11'h0AA;
        in_wrAddr[2*ADDR_W +: ADDR_W]  = 11'h155;
        in_wrData[2*DATA_W +: DATA_W]  = exp_wd;
        start(4'b0100);
        step();
        n_checks++; if (op_gnt !== 4'b0100) begin n_fail++; $display("FAIL wr_gnt: got %b want 0100", op_gnt); end
        in_we = 4'b0100;
        step();
        n_checks++; if (op_yWriteEnable !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", op_yWriteEnable); end
        n_checks++; if (op_yWriteAddress !== 11'h155) begin n_fail++; $display("FAIL wr_wa: got %h want 155", op_yWriteAddress); end
        n_checks++; if (op_writeData !== exp_wd) begin n_fail++; $display("FAIL wr_wd: got %h want %h", op_writeData, exp_wd); end
        n_checks++; if (op_yReadAddress1 !== 11'h0AA) begin n_fail++; $display("FAIL wr_rd1: got %h want 0aa", op_yReadAddress1); end
        n_checks++; if (op_weDropErr !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", op_weDropErr); end
        in_we  = 4'b0000;
        in_req = 4'b0000;
        step();
        step();
        n_checks++; if (op_yWriteEnable !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b want 0", op_yWriteEnable); end
        n_checks++; if (op_yWriteAddress !== 11'h7FF) begin n_fail++; $display("FAIL idle_wa: got %h want 7ff", op_yWriteAddress); end
        n_checks++; if (op_yReadAddress1 !== 11'h7FF) begin n_fail++; $display("FAIL idle_rd1: got %h want 7ff", op_yReadAddress1); end
        n_checks++; if (op_writeData !== exp_wd) begin n_fail++; $display("FAIL idle_wd_held: got %h want %h", op_writeData, exp_wd); end
    endtask

    task automatic test_we_drop();
        start(4'b0010);
        step();
        in_we = 4'b1000;
        step();
        n_checks++; if (op_yWriteEnable !== 1'b0) begin n_fail++; $display("FAIL drop_we: got %b want 0", op_yWriteEnable); end
        n_checks++; if (op_weDropErr !== 1'b1) begin n_fail++; $display("FAIL drop_err_set: got %b want 1", op_weDropErr); end
        in_we = 4'b0000;
        step();
        step();
        step();
        n_checks++; if (op_weDropErr !== 1'b1) begin n_fail++; $display("FAIL drop_err_sticky: got %b want 1", op_weDropErr); end
        in_req = 4'b0000;
        reset  = 1'b0;
        #1;
        n_checks++; if (op_weDropErr !== 1'b0) begin n_fail++; $display("FAIL drop_err_clear: got %b want 0", op_weDropErr); end
        step();
        reset = 1'b1;
    endtask

    task automatic test_rdvalid();
        in_rdAddr1[0 +: ADDR_W] = 11'h010;
        in_rdAddr2[0 +: ADDR_W] = 11'h020;
        start(4'b0001);
        step();
        n_checks++; if (op_gnt !== 4'b0001) begin n_fail++; $display("FAIL rdv_gnt: got %b want 0001", op_gnt); end
        in_req = 4'b0000;
        step();
        n_checks++; if (op_yReadAddress1 !== 11'h010) begin n_fail++; $display("FAIL rdv_rd1: got %h want 010", op_yReadAddress1); end
        n_checks++; if (op_yReadAddress2 !== 11'h020) begin n_fail++; $display("FAIL rdv_rd2: got %h want 020", op_yReadAddress2); end
        n_checks++; if (op_rdValid !== 4'b0000) begin n_fail++; $display("FAIL rdv_edge1: got %b want 0000", op_rdValid); end
        step();
        n_checks++; if (op_rdValid !== 4'b0000) begin n_fail++; $display("FAIL rdv_edge2: got %b want 0000", op_rdValid); end
        step();
        n_checks++; if (op_rdValid !== 4'b0001) begin n_fail++; $display("FAIL rdv_edge3: got %b want 0001", op_rdValid); end
        step();
        n_checks++; if (op_rdValid !== 4'b0000) begin n_fail++; $display("FAIL rdv_edge4: got %b want 0000", op_rdValid); end
    endtask

    task automatic test_ch0_priority();
        start(4'b1000);
        step();
        n_checks++; if (op_gnt !== 4'b1000) begin n_fail++; $display("FAIL ch0_first: got %b want 1000", op_gnt); end
        in_req = 4'b1001;
        step();
`ifdef Y_ARB_STRICT_CH0_EN
        n_checks++; if (op_gnt !== 4'b0001) begin n_fail++; $display("FAIL ch0_preempt: got %b want 0001", op_gnt); end
        for (int c = 0; c < MAX_HOLD + 4; c++) step();
        n_checks++; if (op_gnt !== 4'b0001) begin n_fail++; $display("FAIL ch0_no_hold_limit: got %b want 0001", op_gnt); end
        in_req = 4'b1000;
        step();
        n_checks++; if (op_gnt !== 4'b1000) begin n_fail++; $display("FAIL ch0_release: got %b want 1000", op_gnt); end
`else
        n_checks++; if (op_gnt !== 4'b1000) begin n_fail++; $display("FAIL rr_no_preempt: got %b want 1000", op_gnt); end
        for (int c = 0; c < MAX_HOLD - 2; c++) step();
        n_checks++; if (op_gnt !== 4'b1000) begin n_fail++; $display("FAIL rr_hold_last: got %b want 1000", op_gnt); end
        step();
        n_checks++; if (op_gnt !== 4'b0001) begin n_fail++; $display("FAIL rr_hold_expire: got %b want 0001", op_gnt); end
`endif
        in_req = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        in_req       = '0;
        in_we        = '0;
        in_rdAddr1   = '0;
        in_rdAddr2   = '0;
        in_wrAddr    = '0;
        in_wrData    = '0;
        in_ReadData1 = '0;
        in_ReadData2 = '0;
        test_reset();
        test_reset_midflight();
        test_round_robin();
        test_back_to_back();
        test_write();
        test_we_drop();
        test_rdvalid();
        test_ch0_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
